// File: rtl/memory_responder_pkg.sv
// Shared definitions for the memory responder and the datapath bus.
// - State encoding for the responder FSM (IDLE/WAIT/DONE, 2 bits).
// - Operation encoding latched with each request (read/write).
// - Default RAM address width and bus data width.
// - Helper that flags addresses lying outside the implemented RAM.
package memory_responder_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 4;   // holds wait-state counts 0..15

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // Any set bit above the RAM index field means the word does not exist.
  function automatic logic addr_out_of_range(input logic [31:0] addr, input int aw);
    return (addr >> aw) != 32'd0;
  endfunction

endpackage

// File: rtl/memory_responder_ram_sp.sv
// Synchronous single-port RAM, read-before-write.
// Ports:
//   clk   - clock
//   we    - write enable
//   addr  - word index
//   wdata - write data
//   rdata - registered read data (contents of addr at the previous edge)
// No reset: contents survive a responder reset.
module ram_sp #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder for the MAR/MDR interface.
// Samples a Read/Write request in IDLE, waits WAIT_STATES cycles, performs
// the RAM access, then pulses MemDone (and MemErr for out-of-range
// addresses) for one cycle.
// Ports:
//   clk     - system clock
//   clr     - asynchronous active-low reset
//   MARout  - word address from MAR
//   MDRout  - write data from MDR
//   Read    - read request (level)
//   Write   - write request (level, wins over Read)
//   Mdatain - registered read data, held until the next completed read
//   MemDone - one-cycle completion pulse
//   MemErr  - one-cycle error pulse, coincident with MemDone
//   Busy    - high whenever the FSM is not IDLE
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       MARout,
  input  logic [DATA_W-1:0] MDRout,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] Mdatain,
  output logic              MemDone,
  output logic              MemErr,
  output logic              Busy
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  op_t                op_q, op_d;
  logic [31:0]        addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [DATA_W-1:0]  mdat_q, mdat_d;

  logic               ram_we;
  logic [ADDR_W-1:0]  ram_addr;
  logic [DATA_W-1:0]  ram_rdata;
  logic               oor;

  assign oor = addr_out_of_range(addr_q, ADDR_W);

  // In IDLE the RAM is addressed straight from MARout so that the read word
  // is already registered by the first cycle after sampling; this lets a
  // zero-wait-state read complete without an extra pipeline cycle.
  assign ram_addr = (state_q == S_IDLE) ? MARout[ADDR_W-1:0] : addr_q[ADDR_W-1:0];

  ram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (data_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_RD;
      addr_q  <= '0;
      data_q  <= '0;
      mdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mdat_q  <= mdat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mdat_d  = mdat_q;
    ram_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Read || Write) begin
          op_d    = Write ? OP_WR : OP_RD;
          addr_d  = MARout;
          data_d  = MDRout;
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_DONE;
          if (op_q == OP_WR) begin
            ram_we = !oor;
          end else begin
            mdat_d = oor ? '0 : ram_rdata;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign Mdatain = mdat_q;
  assign MemDone = (state_q == S_DONE);
  assign MemErr  = (state_q == S_DONE) && oor;
  assign Busy    = (state_q != S_IDLE);

endmodule
